// File: rtl/perf_event_monitor.sv
// Performance event monitor: per-channel saturating event counters plus a cycle
// counter, with freeze/auto-stop control, snapshot shadows and a registered read port.
module perf_event_monitor #(
    parameter int NUM_CNT     = 4,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 0,
    parameter int SEL_W       = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [NUM_CNT-1:0] event_i,
    input  logic               freeze_i,
    input  logic               clear_i,
    input  logic               snap_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic [NUM_CNT:0]   ovf_o,
    output logic [1:0]         state_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FROZEN = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] MAX_VAL = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(CYCLE_LIMIT);

    // Index NUM_CNT of the counter/shadow arrays is the cycle counter.
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q    [NUM_CNT+1];
    logic [CNT_W-1:0]   cnt_d    [NUM_CNT+1];
    logic [CNT_W-1:0]   shadow_q [NUM_CNT+1];
    logic [CNT_W-1:0]   shadow_d [NUM_CNT+1];
    logic [NUM_CNT:0]   ovf_q, ovf_d;
    logic [CNT_W-1:0]   rd_data_q, rd_data_d;
    logic [NUM_CNT:0]   hit;
    logic               count_en;

    assign hit = {1'b1, event_i};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        ovf_d     = ovf_q;
        rd_data_d = '0;
        count_en  = 1'b0;

        case (state_q)
            S_IDLE:   if (start_i) state_d = S_RUN;
            S_RUN:    if (freeze_i) state_d = S_FROZEN;
                      else count_en = 1'b1;
            S_FROZEN: if (!freeze_i) state_d = S_RUN;
            default:  state_d = S_DONE;
        endcase

        // Saturate instead of wrapping; a hit while saturated is what flags overflow.
        if (count_en) begin
            for (int k = 0; k <= NUM_CNT; k++) begin
                if (hit[k]) begin
                    if (cnt_q[k] == MAX_VAL) ovf_d[k] = 1'b1;
                    else                     cnt_d[k] = cnt_q[k] + ONE;
                end
            end
            if ((CYCLE_LIMIT != 0) && (cnt_d[NUM_CNT] == LIMIT)) state_d = S_DONE;
        end

        // Shadows take the pre-increment values so a snapshot is edge-consistent.
        if (snap_i) shadow_d = cnt_q;

        for (int k = 0; k <= NUM_CNT; k++) begin
            if (sel_i == SEL_W'(k)) rd_data_d = shadow_q[k];
        end

        if (clear_i) begin
            state_d   = S_IDLE;
            cnt_d     = '{default: '0};
            shadow_d  = '{default: '0};
            ovf_d     = '0;
            rd_data_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '{default: '0};
            shadow_q  <= '{default: '0};
            ovf_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign cycle_o   = cnt_q[NUM_CNT];
    assign ovf_o     = ovf_q;
    assign state_o   = state_q;
    assign done_o    = (state_q == S_DONE);

endmodule

// File: doc/perf_event_monitor.md
PERF_EVENT_MONITOR -- requirements
Module: perf_event_monitor

Interface
REQ-001 Parameter NUM_CNT, default 4, number of event counter channels (1..16).
REQ-002 Parameter CNT_W, default 32, width of every counter, cycle counter included (8..32).
REQ-003 Parameter CYCLE_LIMIT, default 0, number of counted cycles before automatic stop; 0 = no limit.
REQ-004 Parameter SEL_W, default 3, width of sel_i; SEL_W SHALL equal clog2(NUM_CNT+1).
REQ-005 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 start_i  input  1  level; arms counting from IDLE.
REQ-008 event_i  input  NUM_CNT  per-channel event strobe; bit k counts one per cycle when high.
REQ-009 freeze_i  input  1  level; suspends counting while high.
REQ-010 clear_i  input  1  pulse; zeroes all counters and flags, returns to IDLE.
REQ-011 snap_i  input  1  pulse; copies all live counters into shadow registers in one edge.
REQ-012 sel_i  input  SEL_W  shadow read select: 0..NUM_CNT-1 = event shadows; NUM_CNT = cycle shadow.
REQ-013 rd_data_o  output  CNT_W  registered shadow read data.
REQ-014 cycle_o  output  CNT_W  live cycle counter.
REQ-015 ovf_o  output  NUM_CNT+1  sticky saturation flags; bit NUM_CNT belongs to the cycle counter.
REQ-016 state_o  output  2  encoded state: IDLE=0, RUN=1, FROZEN=2, DONE=3.
REQ-017 done_o  output  1  high while in DONE.

Function
REQ-018 States: IDLE -> RUN when start_i=1; RUN -> FROZEN when freeze_i=1; FROZEN -> RUN when freeze_i=0; RUN -> DONE on the edge where the cycle counter becomes CYCLE_LIMIT (CYCLE_LIMIT≠0); DONE is held until clear_i or rst_i.
REQ-019 Counting: on each edge in RUN with freeze_i=0, cycle counter +1 and event counter k +1 when event_i[k]=1.
REQ-020 Counting SHALL NOT occur in IDLE, FROZEN, or DONE, nor on the edge that leaves IDLE.
REQ-021 freeze_i=1 in RUN: the edge entering FROZEN SHALL NOT count.
REQ-022 The RUN->DONE edge SHALL count (final counted cycle), after which cycle_o = CYCLE_LIMIT.
REQ-023 Arithmetic: counters SHALL saturate at 2^CNT_W-1 (no wrap); an event at saturation SHALL set the matching ovf_o bit, which holds until clear_i/rst_i.
REQ-024 Snapshot: snap_i SHALL capture values present before that edge's increment; snap_i is accepted in every state.
REQ-025 Read: rd_data_o SHALL present the shadow selected by sel_i one cycle after sel_i is sampled; sel_i > NUM_CNT SHALL return 0.
REQ-026 Priority: rst_i > clear_i > (snap_i, counting); clear_i zeroes live counters, shadows, ovf_o, rd_data_o and forces IDLE, and same-edge events and snap_i are discarded.
REQ-027 start_i while not in IDLE SHALL be ignored; freeze_i in IDLE or DONE SHALL be ignored.

Reset
REQ-028 On rst_i=1 at an edge: state IDLE, all live counters, shadows, ovf_o, rd_data_o, cycle_o = 0, done_o = 0, regardless of state (mid-RUN, FROZEN, DONE).
REQ-029 After rst_i deasserts the block SHALL remain in IDLE until start_i=1.

Verification (NUM_CNT=2, CNT_W=8, CYCLE_LIMIT=65 unless noted)
REQ-030 Basic count: start, event_i=2'b01 for 10 RUN cycles, snap, sel_i=0 then 2 -> rd_data_o 10 then 10; sel_i=1 -> 0.
REQ-031 Limit: start, event_i=2'b11 continuous -> done_o=1 after 65th counted edge, cycle_o=65, both counters 65 and held for 20 more cycles.
REQ-032 Saturation (CYCLE_LIMIT=0): event_i[0]=1 for 300 cycles -> counter0=255, ovf_o[0]=1, ovf_o[2]=1 (cycle saturated), ovf_o[1]=0.
REQ-033 Freeze: 5 counted cycles, freeze_i=1 for 3 cycles with event_i=2'b11, release, 5 more -> cycle_o=10, counters=10.
REQ-034 Simultaneous: clear_i with snap_i and event_i=2'b11 mid-RUN -> all counters/shadows 0, state_o=0; snap with event at same edge -> shadow = pre-increment value.
REQ-035 Reset in DONE: rst_i one cycle -> done_o=0, state_o=0, cycle_o=0, ovf_o=0, rd_data_o=0.
